// File: rtl/dance_pkg.sv
// Shared constants and helpers for the four-lane dance round sequencer.
package dance_pkg;
    localparam logic [1:0] ST_IDLE      = 2'd0;
    localparam logic [1:0] ST_COUNTDOWN = 2'd1;
    localparam logic [1:0] ST_PLAY      = 2'd2;
    localparam logic [1:0] ST_DONE      = 2'd3;

    localparam int LANES = 4;
    localparam int CNT_W = 8;

    // Taps 8,6,5,4 map to bits 7,5,4,3 of the shift register.
    localparam logic [7:0] LFSR_TAPS = 8'hB8;

    function automatic logic [7:0] lfsr_next(input logic [7:0] s);
        return {s[6:0], ^(s & LFSR_TAPS)};
    endfunction

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction
endpackage

// File: rtl/lane_lfsr.sv
// Free-running 8-bit Fibonacci LFSR; the low two bits pick the target lane.
module lane_lfsr
    import dance_pkg::*;
#(
    parameter logic [7:0] SEED = 8'hA5
) (
    input  logic       CLOCK_50,
    input  logic       resetn,
    output logic [1:0] lfsr
);
    logic [7:0] lfsr_q;
    logic [7:0] lfsr_d;

    always_comb lfsr_d = lfsr_next(lfsr_q);

    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) lfsr_q <= SEED;
        else         lfsr_q <= lfsr_d;
    end

    assign lfsr = lfsr_q[1:0];
endmodule

// File: rtl/dance_round_ctrl.sv
// Round sequencer: countdown, then NUM_BEATS timed beats, each with one target
// lane and a hit window judged as hit or miss.
module dance_round_ctrl
    import dance_pkg::*;
#(
    parameter int         BEAT_CYCLES     = 25_000_000,
    parameter int         WINDOW_CYCLES   = 12_500_000,
    parameter int         NUM_BEATS       = 32,
    parameter int         COUNTDOWN_BEATS = 3,
    parameter logic [7:0] SEED            = 8'hA5
) (
    input  logic             CLOCK_50,
    input  logic             resetn,
    input  logic             start,
    input  logic [LANES-1:0] key_pulse,
    output logic             lane_valid,
    output logic [LANES-1:0] lane_onehot,
    output logic             hit,
    output logic             miss,
    output logic [CNT_W-1:0] score,
    output logic [CNT_W-1:0] misses,
    output logic [CNT_W-1:0] beat_idx,
    output logic [2:0]       countdown,
    output logic [1:0]       state
);
    localparam int BW = $clog2(BEAT_CYCLES);
    localparam int WW = $clog2(WINDOW_CYCLES + 1);
    localparam logic [BW-1:0]    BEAT_LAST = BW'(BEAT_CYCLES - 1);
    localparam logic [WW-1:0]    WIN_LOAD  = WW'(WINDOW_CYCLES);
    localparam logic [CNT_W-1:0] NB        = CNT_W'(NUM_BEATS);
    localparam logic [2:0]       CD        = 3'(COUNTDOWN_BEATS);

    logic [1:0]       lane_sel;
    logic [1:0]       state_q, state_d;
    logic [BW-1:0]    cnt_q, cnt_d;
    logic [WW-1:0]    win_q, win_d;
    logic             lane_valid_q, lane_valid_d;
    logic [LANES-1:0] lane_q, lane_d;
    logic             hit_q, hit_d, miss_q, miss_d;
    logic [CNT_W-1:0] score_q, score_d, misses_q, misses_d;
    logic [CNT_W-1:0] beat_idx_q, beat_idx_d, issued_q, issued_d;
    logic [2:0]       countdown_q, countdown_d;
    logic             tick, start_acc, issue;

    lane_lfsr #(.SEED(SEED)) u_lfsr (
        .CLOCK_50 (CLOCK_50),
        .resetn   (resetn),
        .lfsr     (lane_sel)
    );

    always_comb begin
        state_d      = state_q;
        win_d        = win_q;
        lane_valid_d = lane_valid_q;
        lane_d       = lane_q;
        hit_d        = 1'b0;
        miss_d       = 1'b0;
        score_d      = score_q;
        misses_d     = misses_q;
        beat_idx_d   = beat_idx_q;
        issued_d     = issued_q;
        countdown_d  = countdown_q;
        issue        = 1'b0;

        tick      = (cnt_q == BEAT_LAST);
        start_acc = start && (state_q == ST_IDLE || state_q == ST_DONE);
        cnt_d     = (start_acc || tick) ? '0 : cnt_q + BW'(1);

        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    score_d     = '0;
                    misses_d    = '0;
                    beat_idx_d  = '0;
                    issued_d    = '0;
                    countdown_d = CD;
                    state_d     = ST_COUNTDOWN;
                end
            end
            ST_COUNTDOWN: begin
                if (tick) begin
                    countdown_d = countdown_q - 3'd1;
                    if (countdown_q == 3'd1) begin
                        state_d = ST_PLAY;
                        issue   = 1'b1;
                    end
                end
            end
            default: begin
                if (lane_valid_q) begin
                    win_d = win_q - WW'(1);
                    // A press wins over a timeout landing in the same cycle.
                    if (|key_pulse) begin
                        lane_valid_d = 1'b0;
                        lane_d       = '0;
                        if (key_pulse == lane_q) begin
                            hit_d   = 1'b1;
                            score_d = sat_inc(score_q);
                        end else begin
                            miss_d   = 1'b1;
                            misses_d = sat_inc(misses_q);
                        end
                    end else if (win_q == WW'(1)) begin
                        lane_valid_d = 1'b0;
                        lane_d       = '0;
                        miss_d       = 1'b1;
                        misses_d     = sat_inc(misses_q);
                    end
                end else if (issued_q == NB) begin
                    state_d = ST_DONE;
                end else if (tick) begin
                    issue = 1'b1;
                end
            end
        endcase

        if (issue) begin
            lane_valid_d = 1'b1;
            lane_d       = LANES'(1) << lane_sel;
            win_d        = WIN_LOAD;
            beat_idx_d   = issued_q;
            issued_d     = issued_q + CNT_W'(1);
        end
    end

    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            win_q        <= '0;
            lane_valid_q <= 1'b0;
            lane_q       <= '0;
            hit_q        <= 1'b0;
            miss_q       <= 1'b0;
            score_q      <= '0;
            misses_q     <= '0;
            beat_idx_q   <= '0;
            issued_q     <= '0;
            countdown_q  <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            win_q        <= win_d;
            lane_valid_q <= lane_valid_d;
            lane_q       <= lane_d;
            hit_q        <= hit_d;
            miss_q       <= miss_d;
            score_q      <= score_d;
            misses_q     <= misses_d;
            beat_idx_q   <= beat_idx_d;
            issued_q     <= issued_d;
            countdown_q  <= countdown_d;
        end
    end

    assign lane_valid  = lane_valid_q;
    assign lane_onehot = lane_q;
    assign hit         = hit_q;
    assign miss        = miss_q;
    assign score       = score_q;
    assign misses      = misses_q;
    assign beat_idx    = beat_idx_q;
    assign countdown   = countdown_q;
    assign state       = state_q;
endmodule

// File: tb/tb_dance_round_ctrl.sv
// Directed bench for dance_round_ctrl with BEAT=20, WINDOW=8, 4 beats, countdown 2.
module tb_dance_round_ctrl;
    logic       CLOCK_50;
    logic       resetn;
    logic       start;
    logic [3:0] key_pulse;
    logic       lane_valid;
    logic [3:0] lane_onehot;
    logic       hit, miss;
    logic [7:0] score, misses, beat_idx;
    logic [2:0] countdown;
    logic [1:0] state;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int cyc_s = 0;
    int hit_cnt = 0;
    int miss_cnt = 0;
    int h0, m0, n;
    logic [7:0] m_lfsr;
    logic [3:0] exp_lane, wrong;

    dance_round_ctrl #(
        .BEAT_CYCLES(20), .WINDOW_CYCLES(8), .NUM_BEATS(4),
        .COUNTDOWN_BEATS(2), .SEED(8'hA5)
    ) dut (
        .CLOCK_50    (CLOCK_50),
        .resetn      (resetn),
        .start       (start),
        .key_pulse   (key_pulse),
        .lane_valid  (lane_valid),
        .lane_onehot (lane_onehot),
        .hit         (hit),
        .miss        (miss),
        .score       (score),
        .misses      (misses),
        .beat_idx    (beat_idx),
        .countdown   (countdown),
        .state       (state)
    );

    initial CLOCK_50 = 1'b0;
    always #5 CLOCK_50 = ~CLOCK_50;

    always @(posedge CLOCK_50) begin
        cyc++;
        if (hit)  hit_cnt++;
        if (miss) miss_cnt++;
    end

    // Reference lane generator: x^8+x^6+x^5+x^4+1, shifting left.
    always @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) m_lfsr <= 8'hA5;
        else         m_lfsr <= {m_lfsr[6:0], m_lfsr[7] ^ m_lfsr[5] ^ m_lfsr[4] ^ m_lfsr[3]};
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish, expected finish before 200000 ns");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic start_round();
        start = 1'b1;
        cyc_s = cyc;
        @(negedge CLOCK_50);
        start = 1'b0;
    endtask

    task automatic press(input logic [3:0] k);
        key_pulse = k;
        @(negedge CLOCK_50);
        key_pulse = 4'h0;
    endtask

    // Wait for lane_valid to rise; the lane is drawn from the LFSR value of the tick cycle.
    task automatic wait_lane(input int b);
        logic [7:0] last;
        int k;
        last = m_lfsr;
        k = 0;
        @(negedge CLOCK_50);
        while (!lane_valid && k < 80) begin
            last = m_lfsr;
            @(negedge CLOCK_50);
            k++;
        end
        exp_lane = 4'b0001 << last[1:0];
        chk("lane_rise", 32'(lane_valid), 32'd1);
        chk("lane_onehot", 32'(lane_onehot), 32'(exp_lane));
        chk("beat_idx", 32'(beat_idx), 32'(b));
        chk("rise_cycle", 32'(cyc - cyc_s), 32'(41 + 20 * b));
    endtask

    initial begin
        resetn = 1'b0;
        start = 1'b0;
        key_pulse = 4'h0;
        repeat (2) @(negedge CLOCK_50);
        chk("rst_state", 32'(state), 32'd0);
        chk("rst_lane", 32'({lane_valid, lane_onehot, hit, miss}), 32'd0);
        chk("rst_counts", 32'({score, misses, beat_idx, countdown}), 32'd0);
        resetn = 1'b1;

        // Keys in IDLE are ignored.
        press(4'h1);
        press(4'hF);
        repeat (2) @(negedge CLOCK_50);
        chk("idle_strobes", 32'(hit_cnt + miss_cnt), 32'd0);
        chk("idle_state", 32'(state), 32'd0);

        // Round 1: every beat hit 3 cycles after the lane opens.
        h0 = hit_cnt; m0 = miss_cnt;
        start_round();
        chk("cd_state", 32'(state), 32'd1);
        chk("cd_load", 32'(countdown), 32'd2);
        press(4'hF);
        press(4'h2);
        repeat (18) @(negedge CLOCK_50);
        chk("cd_dec", 32'(countdown), 32'd1);
        chk("cd_state2", 32'(state), 32'd1);
        for (int b = 0; b < 4; b++) begin
            wait_lane(b);
            chk("play_cd_zero", 32'(countdown), 32'd0);
            repeat (3) @(negedge CLOCK_50);
            chk("pre_press_valid", 32'(lane_valid), 32'd1);
            press(exp_lane);
            chk("hit_strobe", 32'({hit, miss}), 32'b10);
            chk("hit_score", 32'(score), 32'(b + 1));
            chk("hit_clears_lane", 32'({lane_valid, lane_onehot}), 32'd0);
            chk("hit_state", 32'(state), 32'd2);
            @(negedge CLOCK_50);
            if (b < 3) begin
                chk("gap_state", 32'(state), 32'd2);
                press(4'hF);
            end else begin
                chk("done_state", 32'(state), 32'd3);
                chk("round_len", 32'(cyc - cyc_s), 32'd106);
            end
        end
        @(negedge CLOCK_50);
        chk("r1_hits", 32'(hit_cnt - h0), 32'd4);
        chk("r1_misses", 32'(miss_cnt - m0), 32'd0);
        chk("r1_final", 32'({score, misses}), 32'({8'd4, 8'd0}));

        // Round 2 from DONE: no presses, start pulsed mid-play.
        start_round();
        chk("restart_state", 32'(state), 32'd1);
        chk("restart_cd", 32'(countdown), 32'd2);
        chk("restart_clear", 32'({score, misses, beat_idx}), 32'd0);
        for (int b = 0; b < 4; b++) begin
            wait_lane(b);
            n = 1;
            do begin
                @(negedge CLOCK_50);
                if (lane_valid) n++;
            end while (lane_valid && n < 20);
            chk("window_len", 32'(n), 32'd8);
            chk("timeout_strobe", 32'({hit, miss}), 32'b01);
            chk("timeout_misses", 32'(misses), 32'(b + 1));
            if (b == 0) begin
                start = 1'b1;
                @(negedge CLOCK_50);
                start = 1'b0;
                @(negedge CLOCK_50);
                chk("play_start_state", 32'(state), 32'd2);
                chk("play_start_keep", 32'({misses, countdown}), 32'({8'd1, 3'd0}));
            end
        end
        @(negedge CLOCK_50);
        chk("r2_done", 32'(state), 32'd3);
        chk("r2_len", 32'(cyc - cyc_s), 32'd110);
        chk("r2_final", 32'({score, misses}), 32'({8'd0, 8'd4}));

        // Round 3: wrong lane, second press, lane plus extra key, last-cycle press.
        start_round();
        chk("r3_clear", 32'({score, misses}), 32'd0);
        wait_lane(0);
        wrong = {exp_lane[2:0], exp_lane[3]};
        @(negedge CLOCK_50);
        press(wrong);
        chk("wrong_strobe", 32'({hit, miss}), 32'b01);
        chk("wrong_misses", 32'(misses), 32'd1);
        chk("wrong_clears", 32'(lane_valid), 32'd0);
        press(exp_lane);
        chk("second_press", 32'({hit, miss}), 32'b00);
        chk("second_score", 32'(score), 32'd0);
        wait_lane(1);
        wrong = {exp_lane[2:0], exp_lane[3]};
        press(exp_lane | wrong);
        chk("multi_strobe", 32'({hit, miss}), 32'b01);
        chk("multi_misses", 32'(misses), 32'd2);
        wait_lane(2);
        repeat (7) @(negedge CLOCK_50);
        chk("last_cycle_valid", 32'(lane_valid), 32'd1);
        press(exp_lane);
        chk("collide_strobe", 32'({hit, miss}), 32'b10);
        @(negedge CLOCK_50);
        chk("collide_after", 32'({hit, miss}), 32'b00);
        chk("collide_counts", 32'({score, misses}), 32'({8'd1, 8'd2}));
        wait_lane(3);
        press(exp_lane);
        chk("r3_hit", 32'({hit, miss}), 32'b10);
        @(negedge CLOCK_50);
        chk("r3_done", 32'(state), 32'd3);
        chk("r3_final", 32'({score, misses}), 32'({8'd2, 8'd2}));

        // Round 4: reset with a lane open, then a clean round.
        start_round();
        wait_lane(0);
        resetn = 1'b0;
        #1;
        chk("arst_state", 32'(state), 32'd0);
        chk("arst_lane", 32'({lane_valid, lane_onehot, hit, miss}), 32'd0);
        chk("arst_counts", 32'({score, misses, beat_idx, countdown}), 32'd0);
        repeat (2) @(negedge CLOCK_50);
        resetn = 1'b1;
        @(negedge CLOCK_50);
        start_round();
        chk("post_rst_state", 32'(state), 32'd1);
        for (int b = 0; b < 4; b++) begin
            wait_lane(b);
            press(exp_lane);
            chk("r4_hit", 32'({hit, miss}), 32'b10);
        end
        @(negedge CLOCK_50);
        chk("r4_done", 32'(state), 32'd3);
        chk("r4_final", 32'({score, misses}), 32'({8'd4, 8'd0}));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
